// File: rtl/uart_cmd_parser.sv
// Byte-level command framer between the UART transceiver and siacore.
// RX parses 0xAA host frames into work/target or loop echoes; TX serialises 0x55 responses.
module uart_cmd_parser #(
  parameter int WORK_LEN = 84,
  parameter int TIMEOUT  = 1000000,
  parameter int TO_W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         new_rx_data,
  output logic [7:0]   tx_data,
  output logic         new_tx_data,
  input  logic         tx_busy,
  output logic [639:0] work,
  output logic [31:0]  target,
  output logic         work_valid,
  input  logic [31:0]  nonce,
  input  logic         nonce_valid,
  output logic         rx_last_byte,
  output logic         tx_last_byte
);

  typedef enum logic [1:0] {R_IDLE, R_CMD, R_LEN, R_DATA} r_state_t;
  typedef enum logic {T_IDLE, T_SEND} t_state_t;

  r_state_t r_state, r_next;
  t_state_t t_state, t_next;

  logic [7:0]      cmd, len, cnt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout, frame_end, work_ok, loop_set;
  logic [639:0]    work_sh;
  logic [23:0]     tgt_sh;
  logic [7:0]      echo_sh, echo_buf;
  logic [31:0]     nonce_buf;
  logic            nonce_pend, loop_pend;
  logic [6:0][7:0] tx_frm;
  logic [2:0]      tx_len, tx_idx;
  logic            tx_start, tx_issue, tx_last;

  assign timeout  = (to_cnt == TO_W'(TIMEOUT));
  assign work_ok  = (cmd == 8'h00) && (len == 8'(WORK_LEN));
  assign loop_set = frame_end && (cmd == 8'h01);

  // ---------------- RX FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    if (new_rx_data) begin
      case (r_state)
        R_IDLE:  if (rx_data == 8'hAA) r_next = R_CMD;
        R_CMD:   r_next = R_LEN;
        R_LEN:   r_next = (rx_data == 8'h00) ? R_IDLE : R_DATA;
        R_DATA:  if (cnt == len - 8'd1) r_next = R_IDLE;
        default: r_next = R_IDLE;
      endcase
    end else if (timeout) begin
      r_next = R_IDLE;
    end
  end

  always_comb begin
    rx_last_byte = 1'b0;
    frame_end    = 1'b0;
    if (new_rx_data && !rst) begin
      if (r_state == R_LEN) begin
        rx_last_byte = (rx_data == 8'h00);
      end else if (r_state == R_DATA) begin
        rx_last_byte = (cnt == len - 8'd1);
        frame_end    = (cnt == len - 8'd1);
      end
    end
  end

  // Idle gap counter; only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    if (rst || new_rx_data || r_state == R_IDLE) to_cnt <= '0;
    else if (!timeout)                           to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= '0;
      len        <= '0;
      cnt        <= '0;
      work_sh    <= '0;
      tgt_sh     <= '0;
      echo_sh    <= '0;
      work       <= '0;
      target     <= '0;
      work_valid <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      if (new_rx_data) begin
        case (r_state)
          R_CMD: cmd <= rx_data;
          R_LEN: begin
            len <= rx_data;
            cnt <= '0;
          end
          R_DATA: begin
            cnt <= cnt + 8'd1;
            if (work_ok) begin
              if (cnt < 8'd80) work_sh[{cnt, 3'b000} +: 8] <= rx_data;
              else             tgt_sh[{cnt[1:0], 3'b000} +: 8] <= rx_data;
            end
            if (cmd == 8'h01 && cnt == 8'd0) echo_sh <= rx_data;
          end
          default: ;
        endcase
      end
      // The final work byte is always target[31:24]; merge it straight in.
      if (frame_end && work_ok) begin
        work       <= work_sh;
        target     <= {rx_data, tgt_sh};
        work_valid <= 1'b1;
      end
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) t_state <= T_IDLE;
    else     t_state <= t_next;
  end

  always_comb begin
    t_next = t_state;
    if (t_state == T_IDLE) begin
      if (nonce_pend || loop_pend) t_next = T_SEND;
    end else if (tx_last) begin
      t_next = T_IDLE;
    end
  end

  // Skipping the cycle after a strobe gives tx_busy time to rise.
  always_comb begin
    tx_start = (t_state == T_IDLE) && (nonce_pend || loop_pend);
    tx_issue = (t_state == T_SEND) && !tx_busy && !new_tx_data;
    tx_last  = tx_issue && (tx_idx == tx_len - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data      <= '0;
      new_tx_data  <= 1'b0;
      tx_last_byte <= 1'b0;
      tx_frm       <= '0;
      tx_len       <= '0;
      tx_idx       <= '0;
      nonce_buf    <= '0;
      nonce_pend   <= 1'b0;
      echo_buf     <= '0;
      loop_pend    <= 1'b0;
    end else begin
      new_tx_data  <= tx_issue;
      tx_last_byte <= tx_last;
      if (tx_issue) begin
        tx_data <= tx_frm[tx_idx];
        tx_idx  <= tx_idx + 3'd1;
      end
      if (tx_start) begin
        tx_idx <= '0;
        if (nonce_pend) begin
          tx_frm     <= {nonce_buf[31:24], nonce_buf[23:16], nonce_buf[15:8],
                         nonce_buf[7:0], 8'h04, 8'h00, 8'h55};
          tx_len     <= 3'd7;
          nonce_pend <= 1'b0;
        end else begin
          tx_frm    <= {24'h0, echo_buf, 8'h01, 8'h01, 8'h55};
          tx_len    <= 3'd4;
          loop_pend <= 1'b0;
        end
      end
      // New requests win over the clear so nothing arriving at frame start is lost.
      if (nonce_valid) begin
        nonce_buf  <= nonce;
        nonce_pend <= 1'b1;
      end
      if (loop_set) begin
        echo_buf  <= (cnt == 8'd0) ? rx_data : echo_sh;
        loop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser against a frame-level reference model
// (expected TX byte queue, expected work/target, expected work_valid count).
module tb_uart_cmd_parser;
  localparam int TO = 40;

  logic         clk = 1'b0, rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         new_rx_data = 1'b0, tx_busy = 1'b0, nonce_valid = 1'b0;
  logic [31:0]  nonce = '0;
  logic [7:0]   tx_data;
  logic         new_tx_data, work_valid, rx_last_byte, tx_last_byte;
  logic [639:0] work;
  logic [31:0]  target;

  always #5 clk = ~clk;

  uart_cmd_parser #(.WORK_LEN(84), .TIMEOUT(TO), .TO_W(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .work(work), .target(target), .work_valid(work_valid),
    .nonce(nonce), .nonce_valid(nonce_valid),
    .rx_last_byte(rx_last_byte), .tx_last_byte(tx_last_byte)
  );

  int n_tests = 0, n_fail = 0;
  logic [639:0] exp_work = '0;
  logic [31:0]  exp_target = '0;
  int           exp_wv = 0, wv_seen = 0, strobes = 0, busy_len = 0;
  logic [8:0]   exp_tx[$];

  task automatic chk(input string tag, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // TX byte monitor against the expected response stream
  always @(negedge clk) begin
    if (!rst) begin
      if (work_valid) wv_seen++;
      if (new_tx_data) begin
        strobes++;
        chk("tx_busy_at_strobe", tx_busy, 0);
        if (exp_tx.size() == 0) chk("tx_extra_strobe", new_tx_data, 0);
        else begin
          logic [8:0] e;
          e = exp_tx.pop_front();
          chk("tx_byte", tx_data, e[7:0]);
          chk("tx_last", tx_last_byte, e[8]);
        end
      end else if (tx_last_byte) begin
        chk("tx_last_no_strobe", tx_last_byte, 0);
      end
    end
  end

  // UART TX model: busy rises the cycle after a strobe and lasts busy_len cycles
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bcnt > 0) begin tx_busy = 1'b1; bcnt--; end
      else tx_busy = 1'b0;
      if (new_tx_data && !rst) bcnt = busy_len;
    end
  end

  task automatic push_nonce(input logic [31:0] n);
    exp_tx.push_back(9'h055); exp_tx.push_back(9'h000); exp_tx.push_back(9'h004);
    exp_tx.push_back({1'b0, n[7:0]});   exp_tx.push_back({1'b0, n[15:8]});
    exp_tx.push_back({1'b0, n[23:16]}); exp_tx.push_back({1'b1, n[31:24]});
  endtask

  task automatic push_echo(input logic [7:0] e);
    exp_tx.push_back(9'h055); exp_tx.push_back(9'h001); exp_tx.push_back(9'h001);
    exp_tx.push_back({1'b1, e});
  endtask

  task automatic pulse_nonce(input logic [31:0] v);
    nonce = v; nonce_valid = 1'b1;
    @(posedge clk); #1;
    nonce_valid = 1'b0;
  endtask

  // Drive one RX strobe (called at posedge+1); optionally pulse nonce in the same cycle
  task automatic send_byte(input logic [7:0] b, input bit last, input bit wv,
                           input bit pn, input logic [31:0] nv);
    rx_data = b; new_rx_data = 1'b1;
    if (pn) begin nonce = nv; nonce_valid = 1'b1; end
    @(negedge clk);
    chk("rx_last_byte", rx_last_byte, last);
    @(posedge clk); #1;
    new_rx_data = 1'b0; nonce_valid = 1'b0; rx_data = 8'($urandom);
    @(negedge clk);
    chk("work_valid_after_byte", work_valid, wv);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input int ln, input logic [7:0] pl[$],
                            input bit pn, input logic [31:0] nv);
    bit good;
    logic [7:0] j;
    good = (c == 8'h00) && (ln == 84);
    repeat ($urandom_range(0, 2)) begin
      j = 8'($urandom);
      if (j == 8'hAA) j = 8'h00;
      send_byte(j, 0, 0, 0, 0);
    end
    if (pn) push_nonce(nv);
    if (c == 8'h01 && ln > 0) push_echo(pl[0]);
    if (good) begin
      for (int i = 0; i < 80; i++) exp_work[8*i +: 8] = pl[i];
      exp_target = {pl[83], pl[82], pl[81], pl[80]};
      exp_wv++;
    end
    send_byte(8'hAA, 0, 0, 0, 0);
    send_byte(c, 0, 0, 0, 0);
    send_byte(8'(ln), ln == 0, 0, 0, 0);
    for (int i = 0; i < ln; i++)
      send_byte(pl[i], i == ln - 1, good && (i == ln - 1), pn && (i == ln - 1), nv);
    chk("work_held", work, exp_work);
    chk("target_held", target, exp_target);
  endtask

  task automatic wait_tx_idle();
    int k;
    k = 0;
    while (exp_tx.size() != 0 && k < 3000) begin @(posedge clk); k++; end
    chk("tx_drain_timeout", exp_tx.size(), 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [31:0] nv;
    int s0, k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_new_tx_data", new_tx_data, 0);
    chk("rst_work", work, 0);
    chk("rst_target", target, 0);
    chk("rst_work_valid", work_valid, 0);
    chk("rst_rx_last", rx_last_byte, 0);
    chk("rst_tx_last", tx_last_byte, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // loop test
    pl = {}; pl.push_back(8'h5A);
    send_frame(8'h01, 1, pl, 0, 0);
    wait_tx_idle();

    // directed work frame
    pl = {};
    for (int i = 0; i < 80; i++) pl.push_back(8'(i));
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33); pl.push_back(8'h44);
    send_frame(8'h00, 84, pl, 0, 0);
    chk("work_byte0", work[7:0], 8'h00);
    chk("work_byte79", work[639:632], 8'h4F);
    chk("target_dir", target, 32'h44332211);

    // nonce with slow UART
    busy_len = 10; s0 = strobes;
    push_nonce(32'hDEADBEEF);
    pulse_nonce(32'hDEADBEEF);
    wait_tx_idle();
    chk("nonce_strobe_count", strobes - s0, 7);
    busy_len = 0;

    // bad frames, then a good echo
    pl = {}; repeat (5) pl.push_back(8'($urandom));
    send_frame(8'h00, 5, pl, 0, 0);
    pl = {}; repeat (2) pl.push_back(8'($urandom));
    send_frame(8'h07, 2, pl, 0, 0);
    pl = {}; pl.push_back(8'h33);
    send_frame(8'h01, 1, pl, 0, 0);
    wait_tx_idle();

    // loop completion and nonce_valid in the same cycle: nonce frame first
    pl = {}; pl.push_back(8'h77);
    send_frame(8'h01, 1, pl, 1, 32'h12345678);
    wait_tx_idle();

    // timeout abandons a partial work frame
    send_byte(8'hAA, 0, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0, 0);
    send_byte(8'd84, 0, 0, 0, 0);
    repeat (10) send_byte(8'($urandom), 0, 0, 0, 0);
    repeat (TO + 20) @(posedge clk);
    #1;
    pl = {}; repeat (84) pl.push_back(8'($urandom));
    send_frame(8'h00, 84, pl, 0, 0);

    // randomized mix
    for (int it = 0; it < 14; it++) begin
      int sel, ln;
      busy_len = $urandom_range(0, 3);
      sel = $urandom_range(0, 4);
      nv = $urandom;
      pl = {};
      case (sel)
        0: begin repeat (84) pl.push_back(8'($urandom)); send_frame(8'h00, 84, pl, 0, 0); end
        1: begin
          ln = $urandom_range(1, 4);
          repeat (ln) pl.push_back(8'($urandom));
          send_frame(8'h01, ln, pl, $urandom_range(0, 1), nv);
        end
        2: begin
          ln = $urandom_range(0, 5);
          repeat (ln) pl.push_back(8'($urandom));
          send_frame(8'($urandom_range(2, 255)), ln, pl, 0, 0);
        end
        3: begin
          ln = $urandom_range(0, 10);
          repeat (ln) pl.push_back(8'($urandom));
          send_frame(8'h00, ln, pl, 0, 0);
        end
        default: begin push_nonce(nv); pulse_nonce(nv); end
      endcase
      wait_tx_idle();
    end
    chk("work_valid_count", wv_seen, exp_wv);

    // reset during a TX frame
    busy_len = 4; s0 = strobes;
    nv = $urandom;
    push_nonce(nv);
    pulse_nonce(nv);
    k = 0;
    while (strobes < s0 + 2 && k < 500) begin @(posedge clk); k++; end
    chk("rst_tx_start_timeout", strobes >= s0 + 2, 1);
    #1;
    rst = 1'b1;
    exp_tx.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_new_tx_data", new_tx_data, 0);
    chk("rst_mid_work", work, 0);
    chk("rst_mid_target", target, 0);
    exp_work = '0; exp_target = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    s0 = strobes;
    repeat (200) @(posedge clk);
    #1;
    chk("no_tx_resume", strobes - s0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
